// File: rtl/mc_cpu_core.sv
// Multicycle MIPS-subset core: shared instruction/data memory with a ready handshake, an illegal-opcode trap and run/step debug control.
// Define PERF_CNT_EN to build the cycle and retired-instruction counters, which are readable through dbg_csr.
module mc_cpu_core #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREG     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [4:0]        dbg_raddr,
  input  logic              dbg_csr,
  output logic [31:0]       dbg_rdata,
  output logic [31:0]       pc,
  output logic [31:0]       ir,
  output logic              halted,
  output logic              trap,
  output logic              retire
);

  localparam int RW = $clog2(NREG);
  localparam logic [RW-1:0] LINK_REG = RW'(NREG - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, aluOut_q, mdr_q;
  logic        stepMode_q, trap_q, retire_q;
  logic [31:0] regs_q [NREG];

  logic [5:0]    opcode, funct;
  logic [RW-1:0] rsIdx, rtIdx, rdIdx, wbIdx;
  logic [31:0]   immS, immZ, opB, aluRes, brTarget, jTarget, wbData;
  logic          legal, isAluR, isJr, isImm, isLw, isSw, isBeq, isBne, isJ, isJal;
  state_t        doneNext;

  assign opcode   = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rsIdx    = ir_q[21 +: RW];
  assign rtIdx    = ir_q[16 +: RW];
  assign rdIdx    = ir_q[11 +: RW];
  assign immS     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign immZ     = {16'h0000, ir_q[15:0]};
  assign brTarget = pc_q + {immS[29:0], 2'b00};
  assign jTarget  = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign wbIdx    = (isLw || isImm) ? rtIdx : rdIdx;
  assign wbData   = isLw ? mdr_q : aluOut_q;
  assign doneNext = (run && !stepMode_q) ? S_FETCH : S_IDLE;

  always_comb begin
    legal  = 1'b1;
    isAluR = 1'b0;
    isJr   = 1'b0;
    isImm  = 1'b0;
    isLw   = 1'b0;
    isSw   = 1'b0;
    isBeq  = 1'b0;
    isBne  = 1'b0;
    isJ    = 1'b0;
    isJal  = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: isAluR = 1'b1;
          6'h08:                             isJr   = 1'b1;
          default:                           legal  = 1'b0;
        endcase
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: isImm = 1'b1;
      6'h23:   isLw  = 1'b1;
      6'h2B:   isSw  = 1'b1;
      6'h04:   isBeq = 1'b1;
      6'h05:   isBne = 1'b1;
      6'h02:   isJ   = 1'b1;
      6'h03:   isJal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // andi/ori zero-extend; every other immediate user (addi, slti, lw, sw) sign-extends.
  always_comb begin
    opB = b_q;
    if (isImm) begin
      opB = (opcode == 6'h0C || opcode == 6'h0D) ? immZ : immS;
    end else if (isLw || isSw) begin
      opB = immS;
    end
    aluRes = a_q + opB;
    if (isAluR) begin
      case (funct)
        6'h22:   aluRes = a_q - opB;
        6'h24:   aluRes = a_q & opB;
        6'h25:   aluRes = a_q | opB;
        6'h2A:   aluRes = {31'd0, $signed(a_q) < $signed(opB)};
        default: aluRes = a_q + opB;
      endcase
    end else if (isImm) begin
      case (opcode)
        6'h0A:   aluRes = {31'd0, $signed(a_q) < $signed(opB)};
        6'h0C:   aluRes = a_q & opB;
        6'h0D:   aluRes = a_q | opB;
        default: aluRes = a_q + opB;
      endcase
    end
  end

  // Main sequencer. pc is advanced in FETCH, so all later targets are relative to PC+4.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      aluOut_q   <= '0;
      mdr_q      <= '0;
      stepMode_q <= 1'b0;
      trap_q     <= 1'b0;
      retire_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run || step) begin
            state_q    <= S_FETCH;
            stepMode_q <= !run;
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + 32'd4;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q <= regs_q[rsIdx];
          b_q <= regs_q[rtIdx];
          if (!legal) begin
            trap_q  <= 1'b1;
            state_q <= S_TRAP;
          end else if (isJ || isJal) begin
            pc_q <= jTarget;
            if (isJal) regs_q[LINK_REG] <= pc_q;
            retire_q <= 1'b1;
            state_q  <= doneNext;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          aluOut_q <= aluRes;
          if (isBeq || isBne || isJr) begin
            if (isJr) pc_q <= a_q;
            else if ((a_q == b_q) == isBeq) pc_q <= brTarget;
            retire_q <= 1'b1;
            state_q  <= doneNext;
          end else if (isLw || isSw) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (isSw) begin
              retire_q <= 1'b1;
              state_q  <= doneNext;
            end else begin
              mdr_q   <= mem_rdata;
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wbIdx != '0) regs_q[wbIdx] <= wbData;
          retire_q <= 1'b1;
          state_q  <= doneNext;
        end
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory outputs decode from registers that stay frozen while a request waits for mem_ready.
  assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_we    = (state_q == S_MEM) && isSw;
  assign mem_addr  = (state_q == S_MEM) ? aluOut_q[ADDR_W+1:2] : pc_q[ADDR_W+1:2];
  assign mem_wdata = b_q;
  assign halted    = (state_q == S_IDLE) || (state_q == S_TRAP);
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign trap      = trap_q;
  assign retire    = retire_q;

`ifdef PERF_CNT_EN
  logic [31:0] cycCnt_q, retCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycCnt_q <= '0;
      retCnt_q <= '0;
    end else begin
      if (!halted) cycCnt_q <= cycCnt_q + 32'd1;
      if (retire_q) retCnt_q <= retCnt_q + 32'd1;
    end
  end
`endif

  always_comb begin
    dbg_rdata = regs_q[dbg_raddr[RW-1:0]];
    if (dbg_csr) begin
`ifdef PERF_CNT_EN
      dbg_rdata = dbg_raddr[0] ? retCnt_q : cycCnt_q;
`else
      dbg_rdata = 32'h0;
`endif
    end
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed testbench for mc_cpu_core with a word-addressed memory model that can stall one chosen address.
// Every check compares against hand-encoded programs and hand-computed results.
module tb_mc_cpu_core;

  logic        clk = 1'b0;
  logic        rst, run, step;
  logic        mem_req, mem_we, mem_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [4:0]  dbg_raddr;
  logic        dbg_csr;
  logic [31:0] dbg_rdata, pc, ir;
  logic        halted, trap, retire;

  logic [31:0] progArr [256];
  logic [31:0] memArr  [256];
  logic [7:0]  slowAddr;
  int          slowWait;
  int          waitCnt;
  int          passCount, checkCount;

  always #5 clk = ~clk;

  mc_cpu_core dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_raddr(dbg_raddr), .dbg_csr(dbg_csr), .dbg_rdata(dbg_rdata),
    .pc(pc), .ir(ir), .halted(halted), .trap(trap), .retire(retire)
  );

  // Memory reloads the program image while rst is high; accesses to slowAddr wait slowWait extra cycles.
  assign mem_ready = mem_req && (waitCnt >= ((mem_addr == slowAddr) ? slowWait : 0));
  assign mem_rdata = memArr[mem_addr];

  always @(posedge clk) begin
    if (rst) begin
      memArr  <= progArr;
      waitCnt <= 0;
    end else if (mem_req && !mem_ready) begin
      waitCnt <= waitCnt + 1;
    end else begin
      waitCnt <= 0;
      if (mem_req && mem_we) memArr[mem_addr] <= mem_wdata;
    end
  end

  task automatic clearProg();
    for (int i = 0; i < 256; i++) progArr[i] = 32'h0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitRetire(output int edges);
    edges = 0;
    do begin
      @(negedge clk);
      step = 1'b0;
      edges++;
    end while (!retire && edges < 100);
  endtask

  task automatic stepInstr(output int edges);
    step = 1'b1;
    waitRetire(edges);
  endtask

  task automatic test_reset();
    clearProg();
    slowAddr = 8'h00;
    slowWait = 5;
    doReset();
    checkCount++; if (pc !== 32'h0) $display("[TB] FAIL reset_pc: got %h, expected 0", pc); else passCount++;
    checkCount++; if (ir !== 32'h0) $display("[TB] FAIL reset_ir: got %h, expected 0", ir); else passCount++;
    checkCount++; if ({mem_req, mem_we, trap, retire, halted} !== 5'b00001)
      $display("[TB] FAIL reset_flags: got req/we/trap/retire/halted=%b, expected 00001", {mem_req, mem_we, trap, retire, halted});
    else passCount++;
    dbg_raddr = 5'd1; #1;
    checkCount++; if (dbg_rdata !== 32'h0) $display("[TB] FAIL reset_reg1: got %h, expected 0", dbg_rdata); else passCount++;
    run = 1'b1;
    repeat (2) @(negedge clk);
    checkCount++; if (mem_req !== 1'b1) $display("[TB] FAIL stalled_fetch_req: got %b, expected 1", mem_req); else passCount++;
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    checkCount++; if ({mem_req, halted} !== 2'b01)
      $display("[TB] FAIL reset_abort_req: got req/halted=%b, expected 01", {mem_req, halted});
    else passCount++;
    rst = 1'b0;
    slowAddr = 8'hFF;
    slowWait = 0;
  endtask

  task automatic test_step();
    int lat;
    clearProg();
    progArr[0] = 32'h2001_0005;
    doReset();
    stepInstr(lat);
    checkCount++; if (lat !== 5) $display("[TB] FAIL step_addi_latency: got %0d edges, expected 5 (idle+4)", lat); else passCount++;
    dbg_raddr = 5'd1; #1;
    checkCount++; if (dbg_rdata !== 32'd5) $display("[TB] FAIL step_addi_r1: got %h, expected 5", dbg_rdata); else passCount++;
    checkCount++; if (pc !== 32'h4) $display("[TB] FAIL step_pc: got %h, expected 4", pc); else passCount++;
    checkCount++; if (ir !== 32'h2001_0005) $display("[TB] FAIL step_ir: got %h, expected 20010005", ir); else passCount++;
    checkCount++; if (halted !== 1'b1) $display("[TB] FAIL step_halted: got %b, expected 1", halted); else passCount++;
    @(negedge clk);
    checkCount++; if (retire !== 1'b0) $display("[TB] FAIL retire_one_cycle: got %b, expected 0", retire); else passCount++;
  endtask

  task automatic test_run();
    int lat;
    clearProg();
    progArr[0] = 32'h2002_FFFF;
    progArr[1] = 32'h0040_182A;
    progArr[2] = 32'h3404_FFFF;
    progArr[3] = 32'hAC02_0008;
    progArr[4] = 32'h8C05_0008;
    doReset();
    run = 1'b1;
    waitRetire(lat);
    checkCount++; if (lat !== 5) $display("[TB] FAIL run_first_latency: got %0d, expected 5", lat); else passCount++;
    waitRetire(lat);
    checkCount++; if (lat !== 4) $display("[TB] FAIL run_slt_cycles: got %0d, expected 4", lat); else passCount++;
    run = 1'b0;
    waitRetire(lat);
    checkCount++; if (lat !== 4) $display("[TB] FAIL run_ori_cycles: got %0d, expected 4", lat); else passCount++;
    checkCount++; if ({halted, pc} !== {1'b1, 32'h0C})
      $display("[TB] FAIL run_stop: got halted=%b pc=%h, expected halted=1 pc=0000000c", halted, pc);
    else passCount++;
    dbg_raddr = 5'd2; #1;
    checkCount++; if (dbg_rdata !== 32'hFFFF_FFFF) $display("[TB] FAIL addi_neg_r2: got %h, expected ffffffff", dbg_rdata); else passCount++;
    dbg_raddr = 5'd3; #1;
    checkCount++; if (dbg_rdata !== 32'h1) $display("[TB] FAIL slt_signed_r3: got %h, expected 1", dbg_rdata); else passCount++;
    dbg_raddr = 5'd4; #1;
    checkCount++; if (dbg_rdata !== 32'h0000_FFFF) $display("[TB] FAIL ori_zext_r4: got %h, expected 0000ffff", dbg_rdata); else passCount++;
    @(negedge clk);
    checkCount++; if (mem_req !== 1'b0) $display("[TB] FAIL idle_no_req: got %b, expected 0", mem_req); else passCount++;
  endtask

  task automatic test_mem_wait();
    int edges, wrCycles, rdCycles, badCycles;
    slowAddr = 8'd2;
    slowWait = 3;
    step = 1'b1;
    edges = 0; wrCycles = 0; badCycles = 0;
    do begin
      @(negedge clk);
      step = 1'b0;
      edges++;
      if (mem_req && mem_we) begin
        wrCycles++;
        if (mem_addr !== 8'd2 || mem_wdata !== 32'hFFFF_FFFF) badCycles++;
      end
    end while (!retire && edges < 100);
    checkCount++; if (edges !== 8) $display("[TB] FAIL sw_wait_latency: got %0d, expected 8 (idle+4+3)", edges); else passCount++;
    checkCount++; if (wrCycles !== 4) $display("[TB] FAIL sw_req_cycles: got %0d, expected 4", wrCycles); else passCount++;
    checkCount++; if (badCycles !== 0) $display("[TB] FAIL sw_hold_stable: got %0d unstable cycles, expected 0", badCycles); else passCount++;
    step = 1'b1;
    edges = 0; rdCycles = 0;
    do begin
      @(negedge clk);
      step = 1'b0;
      edges++;
      if (mem_req && !mem_we && mem_addr == 8'd2) rdCycles++;
    end while (!retire && edges < 100);
    checkCount++; if (edges !== 9) $display("[TB] FAIL lw_wait_latency: got %0d, expected 9 (idle+8)", edges); else passCount++;
    checkCount++; if (rdCycles !== 4) $display("[TB] FAIL lw_req_cycles: got %0d, expected 4", rdCycles); else passCount++;
    dbg_raddr = 5'd5; #1;
    checkCount++; if (dbg_rdata !== 32'hFFFF_FFFF) $display("[TB] FAIL lw_r5: got %h, expected ffffffff", dbg_rdata); else passCount++;
    checkCount++; if (pc !== 32'h14) $display("[TB] FAIL lw_pc: got %h, expected 00000014", pc); else passCount++;
    slowAddr = 8'hFF;
    slowWait = 0;
  endtask

  task automatic test_branch_loop();
    int lat;
    clearProg();
    progArr[0] = 32'h0800_0003;
    progArr[3] = 32'h1000_FFFF;
    doReset();
    run = 1'b1;
    waitRetire(lat);
    checkCount++; if ({lat, pc} !== {32'd3, 32'h0C})
      $display("[TB] FAIL j_latency_pc: got lat=%0d pc=%h, expected lat=3 pc=0000000c", lat, pc);
    else passCount++;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) run = 1'b0;
      waitRetire(lat);
      checkCount++; if ({lat, pc} !== {32'd3, 32'h0C})
        $display("[TB] FAIL beq_loop_iter%0d: got lat=%0d pc=%h, expected lat=3 pc=0000000c", i, lat, pc);
      else passCount++;
    end
    repeat (3) @(negedge clk);
    checkCount++; if ({halted, mem_req, pc} !== {2'b10, 32'h0C})
      $display("[TB] FAIL loop_halt: got halted=%b req=%b pc=%h, expected 1 0 0000000c", halted, mem_req, pc);
    else passCount++;
  endtask

  task automatic test_jal();
    int lat;
    clearProg();
    progArr[0]  = 32'h0800_0004;
    progArr[4]  = 32'h0C00_0010;
    progArr[16] = 32'h1400_0005;
    doReset();
    stepInstr(lat);
    checkCount++; if ({lat, pc} !== {32'd3, 32'h10})
      $display("[TB] FAIL j_to_10: got lat=%0d pc=%h, expected lat=3 pc=00000010", lat, pc);
    else passCount++;
    stepInstr(lat);
    checkCount++; if ({lat, pc} !== {32'd3, 32'h40})
      $display("[TB] FAIL jal_target: got lat=%0d pc=%h, expected lat=3 pc=00000040", lat, pc);
    else passCount++;
    dbg_raddr = 5'd31; #1;
    checkCount++; if (dbg_rdata !== 32'h14) $display("[TB] FAIL jal_link_r31: got %h, expected 00000014", dbg_rdata); else passCount++;
    stepInstr(lat);
    checkCount++; if ({lat, pc} !== {32'd4, 32'h44})
      $display("[TB] FAIL bne_not_taken: got lat=%0d pc=%h, expected lat=4 pc=00000044", lat, pc);
    else passCount++;
  endtask

  task automatic test_trap();
    int edges, reqSeen, retSeen;
    clearProg();
    progArr[0] = 32'hFC00_0000;
    doReset();
    step = 1'b1;
    edges = 0; retSeen = 0;
    do begin
      @(negedge clk);
      step = 1'b0;
      edges++;
      if (retire) retSeen++;
    end while (!trap && edges < 20);
    checkCount++; if ({trap, halted, pc} !== {2'b11, 32'h4})
      $display("[TB] FAIL trap_entry: got trap=%b halted=%b pc=%h, expected 1 1 00000004", trap, halted, pc);
    else passCount++;
    run = 1'b1;
    step = 1'b1;
    reqSeen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      step = 1'b0;
      if (mem_req) reqSeen++;
      if (retire) retSeen++;
    end
    checkCount++; if ({reqSeen, retSeen} !== {32'd0, 32'd0})
      $display("[TB] FAIL trap_ignores_run_step: got req=%0d retire=%0d, expected 0 0", reqSeen, retSeen);
    else passCount++;
    checkCount++; if ({trap, halted, pc} !== {2'b11, 32'h4})
      $display("[TB] FAIL trap_sticky: got trap=%b halted=%b pc=%h, expected 1 1 00000004", trap, halted, pc);
    else passCount++;
    run = 1'b0;
    doReset();
    checkCount++; if ({trap, halted, pc} !== {2'b01, 32'h0})
      $display("[TB] FAIL trap_cleared: got trap=%b halted=%b pc=%h, expected 0 1 00000000", trap, halted, pc);
    else passCount++;
  endtask

  task automatic test_perf();
    int lat;
    clearProg();
    progArr[0] = 32'h2001_0007;
    progArr[1] = 32'h0021_1020;
    progArr[2] = 32'h0041_1822;
    doReset();
    for (int i = 0; i < 3; i++) begin
      stepInstr(lat);
      checkCount++; if (lat !== 5) $display("[TB] FAIL perf_step%0d_latency: got %0d, expected 5", i, lat); else passCount++;
    end
    @(negedge clk);
    dbg_raddr = 5'd2; #1;
    checkCount++; if (dbg_rdata !== 32'd14) $display("[TB] FAIL add_r2: got %h, expected 0000000e", dbg_rdata); else passCount++;
    dbg_raddr = 5'd3; #1;
    checkCount++; if (dbg_rdata !== 32'd7) $display("[TB] FAIL sub_r3: got %h, expected 00000007", dbg_rdata); else passCount++;
    dbg_csr = 1'b1;
    dbg_raddr = 5'd0; #1;
`ifdef PERF_CNT_EN
    checkCount++; if (dbg_rdata !== 32'd12) $display("[TB] FAIL cycle_counter: got %0d, expected 12", dbg_rdata); else passCount++;
    dbg_raddr = 5'd1; #1;
    checkCount++; if (dbg_rdata !== 32'd3) $display("[TB] FAIL retired_counter: got %0d, expected 3", dbg_rdata); else passCount++;
`else
    checkCount++; if (dbg_rdata !== 32'h0) $display("[TB] FAIL csr_cycle_off: got %h, expected 0", dbg_rdata); else passCount++;
    dbg_raddr = 5'd1; #1;
    checkCount++; if (dbg_rdata !== 32'h0) $display("[TB] FAIL csr_retired_off: got %h, expected 0", dbg_rdata); else passCount++;
`endif
    dbg_csr = 1'b0;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    rst        = 1'b1;
    run        = 1'b0;
    step       = 1'b0;
    dbg_raddr  = 5'd0;
    dbg_csr    = 1'b0;
    slowAddr   = 8'hFF;
    slowWait   = 0;
    clearProg();
    test_reset();
    test_step();
    test_run();
    test_mem_wait();
    test_branch_loop();
    test_jal();
    test_trap();
    test_perf();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
